// File: rtl/sigmoid_pkg.sv
// Shared constants for the sigmoid segment selector: breakpoints, per-segment
// gradient/offset coefficients (all Q8.8) and the segment-index type.
package sigmoid_pkg;

  localparam int FRAC = 8;

  // Breakpoints on |x|; each is the inclusive lower bound of the next segment.
  localparam logic [15:0] BP1 = 16'h0100;  // 1.0
  localparam logic [15:0] BP2 = 16'h0260;  // 2.375
  localparam logic [15:0] BP3 = 16'h0500;  // 5.0

  localparam logic [15:0] GRAD0 = 16'h0040;  // 0.25
  localparam logic [15:0] GRAD1 = 16'h0020;
  localparam logic [15:0] GRAD2 = 16'h0008;
  localparam logic [15:0] GRAD3 = 16'h0000;

  localparam logic [15:0] OFF0 = 16'h0080;  // 0.5
  localparam logic [15:0] OFF1 = 16'h00A0;
  localparam logic [15:0] OFF2 = 16'h00D8;
  localparam logic [15:0] OFF3 = 16'h0100;  // 1.0

  typedef logic [1:0] seg_t;

  localparam seg_t SEG0 = 2'd0;
  localparam seg_t SEG1 = 2'd1;
  localparam seg_t SEG2 = 2'd2;
  localparam seg_t SEG3 = 2'd3;

endpackage

// File: rtl/sigmoid_segment_sel_abs_sat.sv
// Combinational saturating absolute value for two's complement samples.
// The most negative code has no positive counterpart and clamps to max positive.
module abs_sat #(
  parameter int BITS = 16
) (
  input  logic [BITS-1:0] a_i,
  output logic [BITS-1:0] y_o
);

  // Negate negative inputs; the most negative value saturates instead of wrapping.
  always_comb begin
    // NOTE: assign a default before any branch so no path leaves y_o unassigned (no latch).
    y_o = a_i;
    if (a_i[BITS-1]) begin
      if (a_i == {1'b1, {(BITS-1){1'b0}}}) begin
        y_o = {1'b0, {(BITS-1){1'b1}}};
      end else begin
        y_o = -a_i;
      end
    end
  end

endmodule

// File: rtl/sigmoid_segment_sel.sv
// Two-stage pipelined segment selector for the piecewise-linear sigmoid.
// S1 registers the sample and its saturated magnitude; S2 picks the segment
// and registers x, gradient, offset and seg. Stall-based valid/ready, no skid.
// Optional feature: define SIGMOID_SATURATE_EN to add the flat seg3 region.
module sigmoid_segment_sel
  import sigmoid_pkg::*;
#(
  parameter int BITS = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [BITS-1:0] in_x,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [BITS-1:0] x,
  output logic [BITS-1:0] gradient,
  output logic [BITS-1:0] offset,
  output logic [1:0]      seg
);

  logic            s1_valid_q;
  logic [BITS-1:0] s1_x_q;
  logic [BITS-1:0] s1_ax_q;
  logic [BITS-1:0] ax_w;

  logic            s2_valid_q;
  logic [BITS-1:0] x_q;
  logic [BITS-1:0] grad_q;
  logic [BITS-1:0] off_q;
  seg_t            seg_q;

  logic [BITS-1:0] grad_d;
  logic [BITS-1:0] off_d;
  seg_t            seg_d;

  logic s1_en;
  logic s2_en;

  abs_sat #(.BITS(BITS)) u_abs_sat (
    .a_i (in_x),
    .y_o (ax_w)
  );

  // Stage enables: a stage may load when it is empty or its consumer is taking its data.
  always_comb begin
    s2_en    = !s2_valid_q || out_ready;
    s1_en    = !s1_valid_q || s2_en;
    in_ready = s1_en;
  end

  // S1 register: capture the accepted sample and its magnitude; hold while stalled.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      s1_valid_q <= 1'b0;
      // NOTE: data registers are reset too, so outputs read as 0 rather than X after reset.
      s1_x_q     <= '0;
      s1_ax_q    <= '0;
    end else if (s1_en) begin
      s1_valid_q <= in_valid;
      if (in_valid) begin
        s1_x_q  <= in_x;
        s1_ax_q <= ax_w;
      end
    end
  end

  // Segment select on the unsigned magnitude; seg2 is the top segment unless saturation is built in.
  always_comb begin
    seg_d  = SEG2;
    grad_d = GRAD2;
    off_d  = OFF2;
    if (s1_ax_q < BP1) begin
      seg_d  = SEG0;
      grad_d = GRAD0;
      off_d  = OFF0;
    end else if (s1_ax_q < BP2) begin
      seg_d  = SEG1;
      grad_d = GRAD1;
      off_d  = OFF1;
    end
`ifdef SIGMOID_SATURATE_EN
    else if (s1_ax_q >= BP3) begin
      seg_d  = SEG3;
      grad_d = GRAD3;
      off_d  = OFF3;
    end
`endif
  end

  // S2 register: output fields, loaded only when a valid S1 sample advances.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid_q <= 1'b0;
      x_q        <= '0;
      grad_q     <= '0;
      off_q      <= '0;
      seg_q      <= SEG0;
    end else if (s2_en) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        x_q    <= s1_x_q;
        grad_q <= grad_d;
        off_q  <= off_d;
        seg_q  <= seg_d;
      end
    end
  end

  assign out_valid = s2_valid_q;
  assign x         = x_q;
  assign gradient  = grad_q;
  assign offset    = off_q;
  assign seg       = seg_q;

endmodule

// File: tb/tb_sigmoid_segment_sel.sv
// Scoreboard bench for sigmoid_segment_sel. Accepted inputs push the reference
// result into a queue; an independent output monitor pops and compares on
// every output transfer. Honours SIGMOID_SATURATE_EN like the design.
module tb_sigmoid_segment_sel;

  typedef struct packed {
    logic [15:0] x;
    logic [15:0] grad;
    logic [15:0] off;
    logic [1:0]  seg;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_x;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] x;
  logic [15:0] gradient;
  logic [15:0] offset;
  logic [1:0]  seg;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  always #5 clk = ~clk;

  sigmoid_segment_sel #(.BITS(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_x      (in_x),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .x         (x),
    .gradient  (gradient),
    .offset    (offset),
    .seg       (seg)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
  endtask

  // Reference: magnitude by integer arithmetic, then the breakpoint table.
  function automatic exp_t model(input logic [15:0] v);
    exp_t e;
    int   s;
    int   a;
    s = int'($signed(v));
    a = (s < 0) ? -s : s;
    if (a > 32767) a = 32767;
    e.x = v;
    if (a < 256) begin
      e.seg = 2'd0; e.grad = 16'h0040; e.off = 16'h0080;
    end else if (a < 608) begin
      e.seg = 2'd1; e.grad = 16'h0020; e.off = 16'h00A0;
`ifdef SIGMOID_SATURATE_EN
    end else if (a >= 1280) begin
      e.seg = 2'd3; e.grad = 16'h0000; e.off = 16'h0100;
`endif
    end else begin
      e.seg = 2'd2; e.grad = 16'h0008; e.off = 16'h00D8;
    end
    return e;
  endfunction

  // Input monitor: every accepted sample pushes its expected result; reset flushes.
  always @(negedge clk) begin
    if (rst) sb.delete();
    else if (in_valid && in_ready) sb.push_back(model(in_x));
  end

  // Output monitor: every output transfer is compared against the queue head.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        check("spurious_out", 32'(x), 32'hDEAD_0000);
      end else begin
        e = sb.pop_front();
        check("out_x", 32'(x), 32'(e.x));
        check("out_gradient", 32'(gradient), 32'(e.grad));
        check("out_offset", 32'(offset), 32'(e.off));
        check("out_seg", 32'(seg), 32'(e.seg));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    out_ready = 1'b1;
    in_valid  = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    tick();
    tick();
    check("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  logic [15:0] dir_vec [12];
  int          sent;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_x      = '0;
    out_ready = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_x", 32'(x), 32'd0);
    check("rst_gradient", 32'(gradient), 32'd0);
    check("rst_offset", 32'(offset), 32'd0);
    check("rst_seg", 32'(seg), 32'd0);

    // Latency: one sample into an empty pipe appears after the second edge.
    in_valid = 1'b1;
    in_x     = 16'h0080;
    tick();
    in_valid = 1'b0;
    check("lat_edge1_out_valid", 32'(out_valid), 32'd0);
    tick();
    check("lat_edge2_out_valid", 32'(out_valid), 32'd1);
    check("lat_x", 32'(x), 32'h0080);
    check("lat_seg", 32'(seg), 32'd0);
    check("lat_gradient", 32'(gradient), 32'h0040);
    check("lat_offset", 32'(offset), 32'h0080);
    drain();

    // Directed boundaries and corner codes, streamed back to back.
    dir_vec = '{16'hFE00, 16'h00FF, 16'h0100, 16'h025F, 16'h0260, 16'h0600,
                16'h8000, 16'h04FF, 16'h0500, 16'h7FFF, 16'hFF01, 16'h0000};
    for (int i = 0; i < 12; i++) begin
      in_valid = 1'b1;
      in_x     = dir_vec[i];
      tick();
    end
    drain();

    // Backpressure: six samples, out_ready low in cycles 3..6.
    sent = 0;
    for (int c = 1; c <= 14; c++) begin
      in_valid  = (sent < 6);
      in_x      = 16'($urandom);
      out_ready = !(c >= 3 && c <= 6);
      #1;
      if (c == 5) begin
        check("bp_in_ready_low", 32'(in_ready), 32'd0);
        check("bp_out_valid_held", 32'(out_valid), 32'd1);
      end
      if (c == 6 && sb.size() != 0) check("bp_hold_x", 32'(x), 32'(sb[0].x));
      if (in_valid && in_ready) sent++;
      tick();
    end
    check("bp_sent", 32'(sent), 32'd6);
    drain();

    // Random traffic with random backpressure, biased toward the breakpoints.
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if ($urandom_range(0, 1) == 0) in_x = 16'($urandom);
      else begin
        in_x = 16'($urandom_range(0, 16'h0600));
        if ($urandom_range(0, 1) == 0) in_x = -in_x;
      end
      tick();
    end
    drain();

    // Reset with both stages full and a simultaneous input: nothing survives.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_x = 16'($urandom);
      tick();
    end
    check("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst  = 1'b1;
    in_x = 16'h0300;
    tick();
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    check("midrst_out_valid", 32'(out_valid), 32'd0);
    check("midrst_in_ready", 32'(in_ready), 32'd1);
    check("midrst_x", 32'(x), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("post_rst_no_output", 32'(out_valid), 32'd0);
    end
    drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
